// File: rtl/trg_mon_pkg.sv
// Shared definitions for the trigger monitor frame builder.
// Holds the FSM state encoding, default frame/window constants and the
// CRC-16-CCITT word update used when TRG_MON_CRC_EN is defined.
package trg_mon_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 8;

    localparam logic [ADDR_W-1:0] DEF_ADDR_FIRST = 8'h02;
    localparam logic [ADDR_W-1:0] DEF_ADDR_LAST  = 8'h22;
    localparam logic [WORD_W-1:0] DEF_HDR_WORD   = 16'hEB90;

    localparam logic [WORD_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [WORD_W-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_SEQ      = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_DATA     = 3'd5,
        ST_CSUM     = 3'd6
    } state_e;

    // CRC-16-CCITT update over one 16-bit word, MSB first, no reflection.
    function automatic logic [WORD_W-1:0] crc16_word(input logic [WORD_W-1:0] crc,
                                                     input logic [WORD_W-1:0] data);
        logic [WORD_W-1:0] c;
        c = crc;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (c[WORD_W-1] ^ data[i]) begin
                c = {c[WORD_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[WORD_W-2:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/trg_mon_csum.sv
// Frame check-word accumulator.
// Build option: TRG_MON_CRC_EN selects CRC-16-CCITT (init FFFF); otherwise
// a modulo-2^16 sum.
// Ports:
//   clk_in, rst_in : clock, async active-high reset (accumulator -> 0)
//   clr_in         : restart accumulation for a new frame
//   add_in         : fold word_in into the accumulator this cycle
//   word_in        : word to accumulate
//   csum_out       : current accumulator value
module trg_mon_csum
    import trg_mon_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clr_in,
    input  logic              add_in,
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] csum_out
);

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_d;
    logic [WORD_W-1:0] acc_init;
    logic [WORD_W-1:0] acc_next;

`ifdef TRG_MON_CRC_EN
    assign acc_init = CRC_INIT;
    assign acc_next = crc16_word(acc_q, word_in);
`else
    assign acc_init = '0;
    assign acc_next = WORD_W'(acc_q + word_in);
`endif

    // Clear wins over add; they never coincide in the frame FSM.
    always_comb begin
        acc_d = acc_q;
        if (clr_in) begin
            acc_d = acc_init;
        end else if (add_in) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign csum_out = acc_q;

endmodule

// File: rtl/trg_mon_frame_builder.sv
// Monitor readout sequencer: reads the monitor bank across
// [ADDR_FIRST, ADDR_LAST] and emits a valid/ready framed stream:
// header, sequence number, data words, check word (tx_last_out).
// Build option: TRG_MON_CRC_EN (check word is CRC-16-CCITT instead of sum).
// Ports:
//   clk_in, rst_in          : clock, async active-high reset
//   mon_req_in              : frame request (pulse or level)
//   rd_out, rd_addr_out     : bank read strobe / address
//   mon_data_in             : bank data, valid the cycle after rd_out
//   tx_data_out/valid/ready/last : outbound frame stream
//   busy_out                : frame in progress
//   frame_cnt_out           : completed frames (wraps)
//   req_drop_cnt_out        : dropped requests (saturates)
module trg_mon_frame_builder
    import trg_mon_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_FIRST = DEF_ADDR_FIRST,
    parameter logic [ADDR_W-1:0] ADDR_LAST  = DEF_ADDR_LAST,
    parameter logic [WORD_W-1:0] HDR_WORD   = DEF_HDR_WORD
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              mon_req_in,
    output logic              rd_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [WORD_W-1:0] mon_data_in,
    output logic [WORD_W-1:0] tx_data_out,
    output logic              tx_valid_out,
    input  logic              tx_ready_in,
    output logic              tx_last_out,
    output logic              busy_out,
    output logic [WORD_W-1:0] frame_cnt_out,
    output logic [WORD_W-1:0] req_drop_cnt_out
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [WORD_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [WORD_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [WORD_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_last_q, tx_last_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;

    logic              hs;
    logic              cs_clr, cs_add;
    logic [WORD_W-1:0] cs_word, cs_val;

    assign hs = tx_valid_q & tx_ready_in;

    trg_mon_csum u_csum (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clr_in   (cs_clr),
        .add_in   (cs_add),
        .word_in  (cs_word),
        .csum_out (cs_val)
    );

    // Next state, counters and registered outputs (decoded from state_d so
    // each output is aligned with the state it belongs to).
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pend_d      = pend_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        tx_last_d   = 1'b0;
        rd_d        = 1'b0;
        busy_d      = 1'b0;
        cs_clr      = 1'b0;
        cs_add      = 1'b0;
        cs_word     = tx_data_q;

        // Requests during a frame: one is remembered, further ones counted.
        if (mon_req_in && (state_q != ST_IDLE)) begin
            if (!pend_q) begin
                pend_d = 1'b1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = WORD_W'(drop_cnt_q + 16'd1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (mon_req_in || pend_q) begin
                    state_d = ST_HDR;
                    pend_d  = 1'b0;
                    addr_d  = ADDR_FIRST;
                    cs_clr  = 1'b1;
                end
            end
            ST_HDR: begin
                if (hs) state_d = ST_SEQ;
            end
            ST_SEQ: begin
                if (hs) begin
                    cs_add  = 1'b1;
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                cs_add    = 1'b1;
                cs_word   = mon_data_in;
                tx_data_d = mon_data_in;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                if (hs) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = ST_CSUM;
                    end else begin
                        addr_d  = ADDR_W'(addr_q + 8'd1);
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_CSUM: begin
                if (hs) begin
                    frame_cnt_d = WORD_W'(frame_cnt_q + 16'd1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        unique case (state_d)
            ST_HDR: begin
                tx_valid_d = 1'b1;
                tx_data_d  = HDR_WORD;
            end
            ST_SEQ: begin
                tx_valid_d = 1'b1;
                tx_data_d  = frame_cnt_q;
            end
            ST_RD_ISSUE: begin
                rd_d = 1'b1;
            end
            ST_DATA: begin
                tx_valid_d = 1'b1;
            end
            ST_CSUM: begin
                // Last add happened in RD_WAIT, so the accumulator is final here.
                tx_valid_d = 1'b1;
                tx_last_d  = 1'b1;
                tx_data_d  = cs_val;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            addr_q      <= ADDR_FIRST;
            pend_q      <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
        end
    end

    assign rd_out           = rd_q;
    assign rd_addr_out      = addr_q;
    assign tx_data_out      = tx_data_q;
    assign tx_valid_out     = tx_valid_q;
    assign tx_last_out      = tx_last_q;
    assign busy_out         = busy_q;
    assign frame_cnt_out    = frame_cnt_q;
    assign req_drop_cnt_out = drop_cnt_q;

endmodule
